// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NCH SRAM-like requester ports onto one downstream
// SRAM-like port. Accepted transactions are tracked in an in-order ID FIFO so
// each downstream data_ok is steered back to the channel that issued it.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin unlocked grant
// instead of fixed lowest-index priority).
module sram_like_arbiter #(
  parameter int NCH   = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NCH-1:0]           up_req,
  input  logic [NCH-1:0]           up_wr,
  input  logic [2*NCH-1:0]         up_size,
  input  logic [AW*NCH-1:0]        up_addr,
  input  logic [(DW/8)*NCH-1:0]    up_wstrb,
  input  logic [DW*NCH-1:0]        up_wdata,
  output logic [NCH-1:0]           up_addr_ok,
  output logic [NCH-1:0]           up_data_ok,
  output logic [DW-1:0]            up_rdata,
  output logic                     dn_req,
  output logic                     dn_wr,
  output logic [1:0]               dn_size,
  output logic [AW-1:0]            dn_addr,
  output logic [DW/8-1:0]          dn_wstrb,
  output logic [DW-1:0]            dn_wdata,
  input  logic                     dn_addr_ok,
  input  logic                     dn_data_ok,
  input  logic [DW-1:0]            dn_rdata,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int SW  = DW / 8;

  logic           lock_valid;
  logic [IDW-1:0] lock_id;
  logic           lock_req;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] id_mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [IDW-1:0] head_id;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] rr_ptr;
`endif

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head_id = id_mem[rd_ptr];

  // Downstream request is blocked while the ID FIFO is full or reset is held.
  assign dn_req = resetn & (|up_req) & ~full;
  assign push   = dn_req & dn_addr_ok;
  assign pop    = resetn & dn_data_ok & ~empty;

  assign up_rdata    = dn_rdata;
  assign outstanding = count;

  // Whether the locked channel is still presenting its request.
  always_comb begin
    lock_req = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (lock_id == IDW'(k)) lock_req = up_req[k];
    end
  end

  // Grant select: a locked channel wins; otherwise priority search.
  always_comb begin
    grant = '0;
    if (lock_valid) begin
      grant = lock_id;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      // Search channels starting at rr_ptr, wrapping modulo NCH.
      logic found;
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        for (int k = 0; k < NCH; k++) begin
          if (!found && up_req[k] && (((int'(rr_ptr) + i) % NCH) == k)) begin
            grant = IDW'(k);
            found = 1'b1;
          end
        end
      end
`else
      for (int k = NCH - 1; k >= 0; k--) begin
        if (up_req[k]) grant = IDW'(k);
      end
`endif
    end
  end

  // Request-field mux; idle cycles present channel 0.
  always_comb begin
    sel      = dn_req ? grant : '0;
    dn_wr    = up_wr[0];
    dn_size  = up_size[1:0];
    dn_addr  = up_addr[AW-1:0];
    dn_wstrb = up_wstrb[SW-1:0];
    dn_wdata = up_wdata[DW-1:0];
    for (int k = 0; k < NCH; k++) begin
      if (sel == IDW'(k)) begin
        dn_wr    = up_wr[k];
        dn_size  = up_size[2*k +: 2];
        dn_addr  = up_addr[AW*k +: AW];
        dn_wstrb = up_wstrb[SW*k +: SW];
        dn_wdata = up_wdata[DW*k +: DW];
      end
    end
  end

  // One-hot handshake returns to the requesters.
  always_comb begin
    up_addr_ok = '0;
    up_data_ok = '0;
    for (int k = 0; k < NCH; k++) begin
      up_addr_ok[k] = push && (grant == IDW'(k));
      up_data_ok[k] = pop && (head_id == IDW'(k));
    end
  end

  // Lock holds a stalled request on dn_* until the downstream accepts it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid <= 1'b0;
      lock_id    <= '0;
    end else if (push) begin
      lock_valid <= 1'b0;
    end else if (lock_valid && !lock_req) begin
      lock_valid <= 1'b0;
    end else if (dn_req) begin
      lock_valid <= 1'b1;
      lock_id    <= grant;
    end
  end

  // ID FIFO storage; contents are qualified by count so need no reset.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= grant;
  end

  // ID FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin pointer moves past the channel just accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (grant == IDW'(NCH - 1)) ? '0 : grant + IDW'(1);
    end
  end
`endif

endmodule
